// File: rtl/led_bit_encoder_pkg.sv
// Shared types for the LED pixel pipeline: encoder FSM states, the GRB pixel
// layout and the encoder's reset bundle.
package pipeline_types;

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        TRESET
    } enc_state_t;

    // s_pixel maps onto this layout, so green is on the wire first.
    typedef struct packed {
        logic [7:0] g;
        logic [7:0] r;
        logic [7:0] b;
    } led_pixel_t;

    typedef struct packed {
        enc_state_t  state;
        logic [31:0] cnt;
        logic        ready;
        logic        dout;
        logic        busy;
        logic        frame_done;
    } enc_reset_t;

    localparam enc_reset_t RESET_VALUES_ENCODER = '{
        state:      TRESET,
        cnt:        32'd0,
        ready:      1'b0,
        dout:       1'b0,
        busy:       1'b1,
        frame_done: 1'b0
    };

endpackage

// File: rtl/led_bit_encoder.sv
// Serialises GRB pixels onto the single-wire LED line, MSB first, one fixed-length
// bit cell per bit, with a latch (treset) low period after each frame's last pixel.
module led_bit_encoder
    import pipeline_types::*;
#(
    parameter int T0H_CYC    = 20,
    parameter int T1H_CYC    = 40,
    parameter int TBIT_CYC   = 62,
    parameter int TRESET_CYC = 2500,
    parameter int PIXEL_W    = 24
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PIXEL_W-1:0] s_pixel,
    input  logic               s_last,
    output logic               o_dout,
    output logic               o_busy,
    output logic               o_frame_done
);

    localparam int CNT_MAX = (TBIT_CYC > TRESET_CYC) ? TBIT_CYC : TRESET_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (PIXEL_W > 1) ? $clog2(PIXEL_W) : 1;

    if (!(T0H_CYC > 0 && T0H_CYC < T1H_CYC && T1H_CYC < TBIT_CYC)) begin : g_bad_cell_timing
        $error("led_bit_encoder: need 0 < T0H_CYC < T1H_CYC < TBIT_CYC");
    end
    if (TRESET_CYC < 1) begin : g_bad_treset
        $error("led_bit_encoder: TRESET_CYC must be >= 1");
    end

    enc_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PIXEL_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               last_q, last_d;
    logic               ready_q, ready_d;
    logic               dout_q, dout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               load;

    function automatic logic [CNT_W-1:0] high_len(input logic bit_val);
        return bit_val ? CNT_W'(T1H_CYC) : CNT_W'(T0H_CYC);
    endfunction

    // Count value on the final LOW cycle of a cell carrying bit_val.
    function automatic logic [CNT_W-1:0] low_end(input logic bit_val);
        return CNT_W'(TBIT_CYC) - high_len(bit_val) - CNT_W'(1);
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        shift_d = shift_q;
        idx_d   = idx_q;
        last_d  = last_q;
        load    = s_valid && ready_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (load) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (cnt_q == high_len(shift_q[PIXEL_W-1]) - CNT_W'(1)) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end
            end
            LOW: begin
                if (cnt_q == low_end(shift_q[PIXEL_W-1])) begin
                    cnt_d = '0;
                    if (idx_q != '0) begin
                        shift_d = shift_q << 1;
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = HIGH;
                    end else if (last_q) begin
                        state_d = TRESET;
                    end else if (load) begin
                        state_d = HIGH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            TRESET: begin
                if (cnt_q == CNT_W'(TRESET_CYC - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = TRESET;
                cnt_d   = '0;
            end
        endcase

        // load is only ever true in IDLE or on the final cycle of a non-last pixel.
        if (load) begin
            shift_d = s_pixel;
            last_d  = s_last;
            idx_d   = IDX_W'(PIXEL_W - 1);
            cnt_d   = '0;
        end

        dout_d  = (state_d == HIGH);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == TRESET) && (cnt_d == CNT_W'(TRESET_CYC - 1));
        ready_d = (state_d == IDLE) ||
                  ((state_d == LOW) && (idx_d == '0) && !last_d &&
                   (cnt_d == low_end(shift_d[PIXEL_W-1])));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RESET_VALUES_ENCODER.state;
            cnt_q   <= CNT_W'(RESET_VALUES_ENCODER.cnt);
            shift_q <= '0;
            idx_q   <= '0;
            last_q  <= 1'b0;
            ready_q <= RESET_VALUES_ENCODER.ready;
            dout_q  <= RESET_VALUES_ENCODER.dout;
            busy_q  <= RESET_VALUES_ENCODER.busy;
            done_q  <= RESET_VALUES_ENCODER.frame_done;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            ready_q <= ready_d;
            dout_q  <= dout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign s_ready      = ready_q;
    assign o_dout       = dout_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;

endmodule

// File: tb/tb_led_bit_encoder.sv
// Self-checking bench for led_bit_encoder: expected per-cycle line waveforms are
// queued at each handshake and compared cycle by cycle by an independent monitor.
module tb_led_bit_encoder;

    localparam int T0H    = 4;
    localparam int T1H    = 8;
    localparam int TBIT   = 12;
    localparam int TRESET = 50;
    localparam int W      = 24;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         s_valid;
    logic         s_ready;
    logic [W-1:0] s_pixel;
    logic         s_last;
    logic         o_dout;
    logic         o_busy;
    logic         o_frame_done;

    int checks = 0;
    int errors = 0;

    // Each entry is {dout, ready, busy, frame_done} for one cycle.
    logic [3:0] exp_q[$];

    led_bit_encoder #(
        .T0H_CYC(T0H),
        .T1H_CYC(T1H),
        .TBIT_CYC(TBIT),
        .TRESET_CYC(TRESET),
        .PIXEL_W(W)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_pixel(s_pixel),
        .s_last(s_last),
        .o_dout(o_dout),
        .o_busy(o_busy),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: the line waveform a pixel must produce, cycle by cycle.
    task automatic push_treset();
        for (int k = 0; k < TRESET; k++)
            exp_q.push_back({1'b0, 1'b0, 1'b1, (k == TRESET - 1)});
    endtask

    task automatic push_pixel(input logic [W-1:0] pix, input logic last);
        for (int i = W - 1; i >= 0; i--) begin
            int h;
            h = pix[i] ? T1H : T0H;
            for (int c = 0; c < TBIT; c++)
                exp_q.push_back({(c < h), (!last && i == 0 && c == TBIT - 1), 1'b1, 1'b0});
        end
        if (last) push_treset();
    endtask

    // Monitor: one comparison per cycle, sampled mid-cycle.
    always @(negedge clk) begin : monitor
        logic [3:0] act_v;
        logic [3:0] exp_v;
        act_v = {o_dout, s_ready, o_busy, o_frame_done};
        if (!reset_n)
            exp_v = 4'b0010;
        else if (exp_q.size() > 0)
            exp_v = exp_q.pop_front();
        else
            exp_v = 4'b0100;
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL line_cycle t=%0t {dout,ready,busy,done} actual=%b expected=%b",
                     $time, act_v, exp_v);
        end
    end

    task automatic release_reset();
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        push_treset();
    endtask

    task automatic assert_reset(input int hold);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        s_valid = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (o_dout !== 1'b0) begin
            errors++;
            $display("FAIL async_reset_dout actual=%b expected=0", o_dout);
        end
        repeat (hold) @(posedge clk);
        release_reset();
    endtask

    task automatic send(input logic [W-1:0] pix, input logic last);
        bit done;
        done = 1'b0;
        @(negedge clk);
        s_valid = 1'b1;
        s_pixel = pix;
        s_last  = last;
        for (int n = 0; n < 5000 && !done; n++) begin
            @(posedge clk);
            if (s_ready) begin
                push_pixel(pix, last);
                done = 1'b1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL handshake_timeout pixel=%h accepted=0 required=1", pix);
        end
    endtask

    task automatic drop_valid();
        @(negedge clk);
        s_valid = 1'b0;
        s_pixel = W'($urandom);
        s_last  = 1'($urandom);
    endtask

    task automatic scramble(input int n);
        repeat (n) begin
            @(negedge clk);
            s_valid = 1'b0;
            s_pixel = W'($urandom);
            s_last  = 1'($urandom);
        end
    endtask

    task automatic wait_idle(input int bound);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < bound && !idle; n++) begin
            @(posedge clk);
            #1;
            if (!o_busy && exp_q.size() == 0) idle = 1'b1;
        end
        checks++;
        if (!idle) begin
            errors++;
            $display("FAIL idle_timeout busy=%b queued=%0d required idle", o_busy, exp_q.size());
        end
    endtask

    initial begin
        reset_n = 1'b0;
        s_valid = 1'b0;
        s_pixel = '0;
        s_last  = 1'b0;
        repeat (3) @(posedge clk);

        // Power-up latch period, then IDLE.
        release_reset();
        wait_idle(200);

        // Single-bit-set last pixel: one long cell, 23 short cells, treset.
        send(24'h800000, 1'b1);
        drop_valid();
        wait_idle(1000);

        // Back-to-back pixels with s_valid held.
        send(24'hFFFFFF, 1'b0);
        send(24'h000000, 1'b1);
        drop_valid();
        wait_idle(1500);

        // Input changes while not ready are ignored.
        send(24'hA5C33C, 1'b0);
        scramble(100);
        wait_idle(1000);
        send(W'($urandom), 1'b1);
        drop_valid();
        wait_idle(1000);

        // Reset in the middle of bit 10.
        send(W'($urandom), 1'b0);
        drop_valid();
        repeat (10 * TBIT + 3) @(posedge clk);
        assert_reset(3);
        wait_idle(200);

        // Idle gap between two non-last pixels of one frame.
        send(W'($urandom), 1'b0);
        drop_valid();
        wait_idle(1000);
        repeat (20) @(posedge clk);
        send(W'($urandom), 1'b0);
        drop_valid();
        wait_idle(1000);
        send(W'($urandom), 1'b1);
        drop_valid();
        wait_idle(1000);

        // Random pixels, random frame boundaries and gaps.
        for (int k = 0; k < 12; k++) begin
            send(W'($urandom), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                drop_valid();
                repeat ($urandom_range(0, 15)) @(posedge clk);
            end
        end
        send(W'($urandom), 1'b1);
        drop_valid();
        wait_idle(2000);
        repeat (5) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
